// File: rtl/abc_pattern_gen_pkg.sv
// Shared types and helpers for the three-bus equality pattern generator.
package abc_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_DIAG = 1'b1;

  // Widest word the golden helper accepts; narrower callers zero-extend.
  localparam int EQ_MAX_W = 32;

  function automatic logic eq3(input logic [EQ_MAX_W-1:0] a,
                               input logic [EQ_MAX_W-1:0] b,
                               input logic [EQ_MAX_W-1:0] c);
    return (a == b) && (b == c);
  endfunction

endpackage

// File: rtl/abc_pattern_gen_eq3_golden.sv
// Golden reference for the comparator under test: eq = (a == b == c).
module eq3_golden
  import abc_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             eq
);

  logic [EQ_MAX_W-1:0] a_x;
  logic [EQ_MAX_W-1:0] b_x;
  logic [EQ_MAX_W-1:0] c_x;

  assign a_x = EQ_MAX_W'(a);
  assign b_x = EQ_MAX_W'(b);
  assign c_x = EQ_MAX_W'(c);
  assign eq  = eq3(a_x, b_x, c_x);

endmodule

// File: rtl/abc_pattern_gen.sv
// Drives A/B/C patterns into the equality comparator, counts f_in matches
// and flags any response that disagrees with the golden model.
//
// state | meaning
// IDLE  | buses parked at zero, waiting for start
// RUN   | one pattern per cycle, f_in sampled at the end of each cycle
// DONE  | one-cycle done pulse, results held
module abc_pattern_gen
  import abc_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               f_in,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic [3*WIDTH:0]   match_cnt,
  output logic               err
);

  localparam int CW = 3 * WIDTH;
  localparam int MW = CW + 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            mode_q;
  logic            golden;
  logic            last;

  assign cnt_nxt = cnt + 1'b1;

  // Diagonal runs never touch the upper cnt bits, so the low word alone marks the end.
  assign last = (mode_q == MODE_DIAG) ? (&cnt[WIDTH-1:0]) : (&cnt);

  eq3_golden #(.WIDTH(WIDTH)) u_golden (
    .a  (A),
    .b  (B),
    .c  (C),
    .eq (golden)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= MODE_FULL;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt       <= '0;
            match_cnt <= '0;
            err       <= 1'b0;
            mode_q    <= mode;
            A         <= '0;
            B         <= '0;
            C         <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          match_cnt <= match_cnt + MW'(f_in);
          err       <= err | (f_in != golden);
          if (last) begin
            A     <= '0;
            B     <= '0;
            C     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt_nxt;
            if (mode_q == MODE_DIAG) begin
              A <= cnt_nxt[WIDTH-1:0];
              B <= cnt_nxt[WIDTH-1:0];
              C <= cnt_nxt[WIDTH-1:0];
            end else begin
              {A, B, C} <= cnt_nxt;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/abc_pattern_gen.md
# abc_pattern_gen

Sequential stimulus and checking initiator for the three-bus equality comparator (F = 1 iff A = B = C). On a start request it drives registered A/B/C patterns into the comparator, one per cycle. It samples the comparator's F response each cycle, counts matches, and flags any disagreement with an internal golden model. It sits beside the comparator in the self-test path and reports through a busy/done handshake.

## Interface
- WIDTH, 3, bit width of each of A, B, C.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- mode  in  1  0 = full sweep of all 2^(3·WIDTH) patterns; 1 = diagonal sweep A=B=C=k, k = 0..2^WIDTH−1; latched on accepted start.
- f_in  in  1  comparator response to current A/B/C, combinational from them.
- A, B, C  out  WIDTH  registered pattern buses.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on run completion.
- match_cnt  out  3·WIDTH+1  number of sampled cycles with f_in = 1.
- err  out  1  sticky: some sampled f_in differed from golden A==B && B==C.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A=B=C=0, busy=0, done=0.
  - On start=1: clear cnt, match_cnt, err; latch mode; go to RUN.
- RUN:
  - Pattern from 3·WIDTH-bit cnt. Full mode: {A,B,C} = cnt. Diagonal mode: A=B=C=cnt[WIDTH−1:0].
  - Each clock edge: sample f_in; match_cnt += f_in; err |= (f_in != golden); cnt += 1.
  - Last pattern: cnt = 2^(3·WIDTH)−1 (full) or 2^WIDTH−1 (diagonal). After sampling it, go to DONE; cnt does not wrap into a new pattern.
  - start is ignored.
- DONE:
  - done=1 for exactly one cycle, A=B=C=0, then return to IDLE.
  - start is ignored in DONE; it is honoured from the next IDLE cycle.
- match_cnt and err hold their values from done until the next accepted start.
- Reset, including mid-run: state IDLE, cnt=0, A=B=C=0, busy=0, done=0, match_cnt=0, err=0. Any run in progress is abandoned with no done pulse.

## Timing
- start sampled at edge N. The first pattern appears on A/B/C after edge N, and busy rises after edge N.
- One pattern per cycle. f_in for pattern i is sampled at the edge ending the cycle in which pattern i is driven, giving zero extra latency.
- RUN lasts 2^(3·WIDTH) cycles in full mode (512 for WIDTH=3) and 2^WIDTH cycles in diagonal mode (8).
- done is high in the cycle after the last sample. match_cnt and err are final in that same cycle.
- Start-to-done: 2^(3·WIDTH)+1 cycles (full), 2^WIDTH+1 cycles (diagonal).

## Structure
- Shared package:
  - state enum {IDLE, RUN, DONE};
  - mode encodings MODE_FULL=0, MODE_DIAG=1;
  - function computing golden equality of three WIDTH-bit words.
- One sub-module: eq3_golden, a combinational WIDTH-parameterised A==B==C model feeding the err compare. All sequencing stays in the top.

## Test plan
- Reset, then start with mode=0 and a correct comparator -> 512 busy cycles, done pulse at start+513, match_cnt=8, err=0.
- mode=1 with a correct comparator -> A=B=C steps 0..7 over 8 cycles, match_cnt=8, err=0, done at start+9.
- mode=0 with f_in stuck at 1 -> match_cnt=512, err=1. With f_in stuck at 0 -> match_cnt=0, err=1.
- start held high throughout a run -> no restart during RUN or DONE; a new run begins from the IDLE cycle after done; counters are cleared.
- rst asserted at RUN cycle 100 -> outputs zero immediately, no done pulse. A following start performs a clean full run with match_cnt=8.
- Comparator faulty only on pattern A=5, B=5, C=4 (f_in=1) -> err=1, match_cnt=9.
